replay_cmd_decoder: RTL

//   Parametrised successor of the single-channel command decoder. Sits between the command FIFO and the RS/memory

---
 rtl/replay_cmd_decoder_pkg.sv | 43 ++++
 rtl/replay_cmd_decoder_grant_watchdog.sv | 43 ++++
 rtl/replay_cmd_decoder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/replay_cmd_decoder_pkg.sv
// ----------------------------------------------------------------------------
// replay_cmd_decoder_pkg
//   Shared types for the replay command decoder: opcode and FSM state enums,
//   the default packet geometry and the packet typedefs derived from it, plus
//   small elaboration-time helpers for the iteration counter.
// ----------------------------------------------------------------------------
package replay_cmd_decoder_pkg;

    localparam int DEF_PKT_W = 32;
    localparam int DEF_OP_W  = 3;

    typedef enum logic [2:0] {
        OP_TASK    = 3'b000,
        OP_REPLAY  = 3'b001,
        OP_NUM_FV  = 3'b010,
        OP_WEIGHTS = 3'b011,
        OP_CONFIG  = 3'b100,
        OP_ABORT   = 3'b101
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GRANT,
        ST_WAIT_DRAIN,
        ST_WAIT_STREAM,
        ST_WAIT_DONE
    } state_e;

    // Task payload to the RS (opcode stripped) and full packet to memory.
    typedef logic [DEF_PKT_W-DEF_OP_W-1:0] dp_task2rs_t;
    typedef logic [DEF_PKT_W-1:0]          dp2mem_t;

    // Iteration counter width; keeps at least one bit for MAX_REPLAY == 1.
    function automatic int iter_width(input int max_replay);
        return (max_replay > 1) ? $clog2(max_replay) : 1;
    endfunction

    // Clamp a programmed last iteration into the supported range.
    function automatic int sat_iter(input int val, input int max_replay);
        return (val >= max_replay) ? max_replay - 1 : val;
    endfunction

endpackage

// File: rtl/replay_cmd_decoder_grant_watchdog.sv
// ----------------------------------------------------------------------------
// replay_cmd_decoder_grant_watchdog
//   Counts consecutive cycles spent waiting for a memory grant. When the wait
//   reaches WDOG_CYC cycles the error flag is raised and stays set until reset;
//   the counter itself clears whenever the wait ends.
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low reset
//   count_en     in   1 = decoder is waiting for a grant this cycle
//   err_timeout  out  sticky timeout flag
// ----------------------------------------------------------------------------
module replay_cmd_decoder_grant_watchdog #(
    parameter int WDOG_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    output logic err_timeout
);

    localparam int CNT_W = $clog2(WDOG_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // NOTE: sequential state is assigned with <= only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else if (!count_en) begin
            wait_cnt    <= '0;
        end else begin
            // Saturate so a very long wait cannot wrap the counter.
            if (wait_cnt != CNT_W'(WDOG_CYC))
                wait_cnt <= wait_cnt + CNT_W'(1);
            // This edge completes the WDOG_CYC-th waiting cycle.
            if (wait_cnt == CNT_W'(WDOG_CYC - 1))
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/replay_cmd_decoder.sv
// ----------------------------------------------------------------------------
// replay_cmd_decoder
//   Decodes opcode packets at the head of the command FIFO. Iteration-enabled
//   tasks go straight to the RS; skipped tasks are parked and written back to
//   memory once the arbiter grants. REPLAY packets wait for the array to drain,
//   then either start the next replay iteration or, on the last one, signal
//   cntl_done and wait for the final vertex update before reporting
//   task_complete and rewinding the iteration counter.
// Ports
//   clk, reset           clock; synchronous active-low reset
//   cmd_valid/cmd_packet command FIFO head;  fifo_stall: 1 = head not consumed
//   rs_task_valid/_packet task to the RS (opcode stripped);  rs_empty from RS
//   mem_req/mem_grant    memory arbiter handshake
//   mem_pkt_valid/mem_pkt held packet to memory
//   bank_busy_in/pe_idle per-bank busy, per-PE idle (drain detection)
//   stream_end/vertex_done stream and final-update completion pulses
//   stream_begin         1-cycle pulse after a NUM_FV decode
//   num_fv, weights_boundary, replay_iter, last_iter   configuration/status
//   cntl_done/task_complete  1-cycle completion strobes
//   err_grant_timeout    sticky grant-wait watchdog error
// ----------------------------------------------------------------------------
module replay_cmd_decoder
    import replay_cmd_decoder_pkg::*;
#(
    parameter  int PKT_W      = DEF_PKT_W,
    parameter  int OP_W       = DEF_OP_W,
    parameter  int NUM_PE     = 4,
    parameter  int MAX_REPLAY = 4,
    parameter  int MASK_LSB   = 10,
    parameter  int FV_W       = 5,
    parameter  int WB_W       = 4,
    parameter  int WDOG_CYC   = 1024,
    localparam int ITER_W     = iter_width(MAX_REPLAY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [PKT_W-1:0]      cmd_packet,
    output logic                  fifo_stall,
    output logic                  rs_task_valid,
    output logic [PKT_W-OP_W-1:0] rs_task_packet,
    input  logic                  rs_empty,
    output logic                  mem_req,
    input  logic                  mem_grant,
    output logic                  mem_pkt_valid,
    output logic [PKT_W-1:0]      mem_pkt,
    input  logic [NUM_PE-1:0]     bank_busy_in,
    input  logic [NUM_PE-1:0]     pe_idle,
    input  logic                  stream_end,
    input  logic                  vertex_done,
    output logic                  stream_begin,
    output logic [FV_W-1:0]       num_fv,
    output logic [WB_W-1:0]       weights_boundary,
    output logic [ITER_W-1:0]     replay_iter,
    output logic [ITER_W-1:0]     last_iter,
    output logic                  cntl_done,
    output logic                  task_complete,
    output logic                  err_grant_timeout
);

    state_e                 state;
    logic [PKT_W-1:0]       held_pkt;

    opcode_e                op;
    logic [MAX_REPLAY-1:0]  iter_mask;
    logic                   task_hit;
    logic                   drained;
    logic                   at_last;
    logic                   grant_ok;
    logic [ITER_W-1:0]      cfg_last;

    assign op        = opcode_e'(cmd_packet[PKT_W-1 -: OP_W]);
    assign iter_mask = cmd_packet[MASK_LSB +: MAX_REPLAY];
    assign task_hit  = iter_mask[replay_iter];
    assign drained   = !(|bank_busy_in) && rs_empty && (&pe_idle);
    assign at_last   = (replay_iter == last_iter);
    assign grant_ok  = mem_grant && mem_req;
    assign cfg_last  = ITER_W'(sat_iter(int'(cmd_packet[ITER_W-1:0]), MAX_REPLAY));

    assign rs_task_packet = rs_task_valid ? cmd_packet[PKT_W-OP_W-1:0] : '0;
    assign mem_pkt        = held_pkt;

    // ------------------------------------------------------------------
    // Combinational handshake strobes; all forced low while in reset.
    // ------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a value unassigned (which would infer a latch).
    always_comb begin
        fifo_stall    = 1'b0;
        rs_task_valid = 1'b0;
        mem_pkt_valid = 1'b0;
        cntl_done     = 1'b0;
        task_complete = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (op == OP_TASK) begin
                            rs_task_valid = task_hit;
                            // A skipped task stays at the head until granted.
                            fifo_stall    = !task_hit;
                        end else if (op == OP_REPLAY) begin
                            fifo_stall    = 1'b1;
                        end
                    end
                end
                ST_WAIT_GRANT: begin
                    fifo_stall    = !grant_ok;
                    mem_pkt_valid = grant_ok;
                end
                ST_WAIT_DRAIN: begin
                    fifo_stall    = !drained;
                    cntl_done     = drained && at_last;
                    mem_pkt_valid = drained && !at_last;
                end
                ST_WAIT_DONE: begin
                    fifo_stall    = 1'b1;
                    task_complete = vertex_done;
                end
                default: begin
                    fifo_stall    = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and configuration registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= ST_IDLE;
            // NOTE: the held packet is a single register, not a memory array,
            // so it is reset to keep mem_pkt deterministic after reset.
            held_pkt         <= '0;
            mem_req          <= 1'b0;
            stream_begin     <= 1'b0;
            num_fv           <= '0;
            weights_boundary <= '0;
            replay_iter      <= '0;
            last_iter        <= ITER_W'(MAX_REPLAY - 1);
        end else begin
            stream_begin <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (op)
                            OP_TASK: begin
                                if (!task_hit) begin
                                    held_pkt <= cmd_packet;
                                    mem_req  <= 1'b1;
                                    state    <= ST_WAIT_GRANT;
                                end
                            end
                            OP_REPLAY: begin
                                held_pkt <= cmd_packet;
                                state    <= ST_WAIT_DRAIN;
                            end
                            OP_NUM_FV: begin
                                num_fv       <= cmd_packet[FV_W-1:0];
                                stream_begin <= 1'b1;
                            end
                            OP_WEIGHTS: begin
                                weights_boundary <= cmd_packet[WB_W-1:0];
                                state            <= ST_WAIT_STREAM;
                            end
                            OP_CONFIG: begin
                                last_iter <= cfg_last;
                            end
                            OP_ABORT: begin
                                replay_iter <= '0;
                                mem_req     <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT_GRANT: begin
                    if (grant_ok) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_WAIT_DRAIN: begin
                    if (drained) begin
                        // The last-iteration check comes first, so the
                        // counter never runs past last_iter.
                        if (at_last) begin
                            state <= ST_WAIT_DONE;
                        end else begin
                            replay_iter <= replay_iter + ITER_W'(1);
                            state       <= ST_WAIT_STREAM;
                        end
                    end
                end
                ST_WAIT_STREAM: begin
                    if (stream_end)
                        state <= ST_IDLE;
                end
                ST_WAIT_DONE: begin
                    if (vertex_done) begin
                        replay_iter <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    replay_cmd_decoder_grant_watchdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_grant_watchdog (
        .clk         (clk),
        .reset       (reset),
        .count_en    (state == ST_WAIT_GRANT),
        .err_timeout (err_grant_timeout)
    );

endmodule
